// File: rtl/display_capture_if.sv
// Scanned display bus (pos/num/point) plus the capture block's reconstructed outputs.
// Optional output changed exists only when DISPLAY_CAPTURE_CHANGE_EN is defined.
interface display_capture_if;
    // Valid-only stream: a beat is pos/num/point in any cycle with scan_valid=1.
    // There is no ready; the receiver accepts every beat and never stalls the source.
    logic       scan_valid;
    logic [1:0] pos;
    logic [3:0] num;
    logic       point;

    logic [3:0] num1;
    logic [3:0] num2;
    logic [3:0] num3;
    logic [3:0] num4;
    logic       frame_done;
    logic       seq_err;
    logic       point_err;
    logic       locked;
    logic       stale;
    logic       dbg_state;
`ifdef DISPLAY_CAPTURE_CHANGE_EN
    logic       changed;
`endif

    modport master (
        output scan_valid, pos, num, point,
        input  num1, num2, num3, num4, frame_done, seq_err, point_err,
        input  locked, stale, dbg_state
`ifdef DISPLAY_CAPTURE_CHANGE_EN
        , input changed
`endif
    );

    modport slave (
        input  scan_valid, pos, num, point,
        output num1, num2, num3, num4, frame_done, seq_err, point_err,
        output locked, stale, dbg_state
`ifdef DISPLAY_CAPTURE_CHANGE_EN
        , output changed
`endif
    );
endinterface

// File: rtl/display_capture.sv
// Receiver for the 4-digit scanned display bus: checks slot order and point placement,
// commits complete frames to parallel digits. DISPLAY_CAPTURE_CHANGE_EN adds the changed pulse.
module display_capture #(
    parameter int POS_SKEW       = 1,
    parameter int POINT_SLOT     = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic              clk,
    input logic              rst,
    display_capture_if.slave bus
);
    localparam int              CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   SAT   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]      SKEW  = 2'(POS_SKEW);
    localparam logic [1:0]      PSLOT = 2'(POINT_SLOT);

    typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

    state_t        state;
    logic [1:0]    expected;
    logic [3:0]    sh0, sh1, sh2;
    logic [3:0]    d1, d2, d3, d4;
    logic [CW-1:0] tcount;
    logic          frame_done_r, seq_err_r, point_err_r, locked_r, stale_r;
    logic [1:0]    slot;
    logic          pt_ok;
    logic [CW-1:0] tnext;

    // num/point on the bus lag pos by POS_SKEW slots; wrap arithmetic gives the real slot.
    assign slot  = bus.pos - SKEW;
    assign pt_ok = (bus.point == (slot == PSLOT));
    assign tnext = tcount + CW'(1);

`ifdef DISPLAY_CAPTURE_CHANGE_EN
    logic changed_r;
    assign bus.changed = changed_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HUNT;
            expected     <= 2'd0;
            sh0          <= 4'd0;
            sh1          <= 4'd0;
            sh2          <= 4'd0;
            d1           <= 4'd0;
            d2           <= 4'd0;
            d3           <= 4'd0;
            d4           <= 4'd0;
            tcount       <= '0;
            frame_done_r <= 1'b0;
            seq_err_r    <= 1'b0;
            point_err_r  <= 1'b0;
            locked_r     <= 1'b0;
            stale_r      <= 1'b0;
`ifdef DISPLAY_CAPTURE_CHANGE_EN
            changed_r    <= 1'b0;
`endif
        end else begin
            frame_done_r <= 1'b0;
            seq_err_r    <= 1'b0;
            point_err_r  <= 1'b0;
`ifdef DISPLAY_CAPTURE_CHANGE_EN
            changed_r    <= 1'b0;
`endif
            if (bus.scan_valid) begin
                tcount  <= '0;
                stale_r <= 1'b0;
                unique case (state)
                    HUNT: begin
                        if (slot == 2'd0 && pt_ok) begin
                            sh0      <= bus.num;
                            expected <= 2'd1;
                            state    <= COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (slot != expected) begin
                            seq_err_r <= 1'b1;
                            locked_r  <= 1'b0;
                            state     <= HUNT;
                        end else if (!pt_ok) begin
                            point_err_r <= 1'b1;
                            locked_r    <= 1'b0;
                            state       <= HUNT;
                        end else begin
                            expected <= slot + 2'd1;
                            unique case (slot)
                                2'd0: sh0 <= bus.num;
                                2'd1: sh1 <= bus.num;
                                2'd2: sh2 <= bus.num;
                                default: begin
                                    // The slot-3 digit goes straight to the outputs.
                                    d1           <= sh2;
                                    d2           <= sh1;
                                    d3           <= sh0;
                                    d4           <= bus.num;
                                    frame_done_r <= 1'b1;
                                    locked_r     <= 1'b1;
`ifdef DISPLAY_CAPTURE_CHANGE_EN
                                    changed_r    <= ({sh2, sh1, sh0, bus.num} != {d1, d2, d3, d4});
`endif
                                end
                            endcase
                        end
                    end
                    default: state <= HUNT;
                endcase
            end else if (tcount != SAT) begin
                tcount <= tnext;
                if (tnext == SAT) begin
                    stale_r  <= 1'b1;
                    locked_r <= 1'b0;
                    state    <= HUNT;
                end
            end
        end
    end

    assign bus.num1       = d1;
    assign bus.num2       = d2;
    assign bus.num3       = d3;
    assign bus.num4       = d4;
    assign bus.frame_done = frame_done_r;
    assign bus.seq_err    = seq_err_r;
    assign bus.point_err  = point_err_r;
    assign bus.locked     = locked_r;
    assign bus.stale      = stale_r;
    assign bus.dbg_state  = (state == COLLECT);
endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Receiving end of the 4-digit scanned display bus (pos / num / point) used by the stopwatch.
- Samples the time-multiplexed stream and checks slot order and decimal-point placement.
- Reconstructs the four BCD digits as stable parallel registers, for a second display, a readback path or a bench monitor.
- Sits on the system clock; each bus beat is qualified by scan_valid.

Parameters:
- POS_SKEW, 1: slot carried by a beat = (pos - POS_SKEW) mod 4. The num/point on the bus belong to the slot one before the pos value presented with them.
- POINT_SLOT, 0: the only slot whose point bit must be 1.
- TIMEOUT_CYCLES, 1024: clk cycles without scan_valid before the stream is declared stale. Must be ≥2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- scan_valid  in  1  qualifies pos/num/point for one clk cycle
- pos  in  2  bus digit position
- num  in  4  bus digit value
- point  in  1  bus decimal-point bit
- num1  out  4  committed digit for slot 2
- num2  out  4  committed digit for slot 1
- num3  out  4  committed digit for slot 0 (point digit)
- num4  out  4  committed digit for slot 3
- frame_done  out  1  one-cycle pulse: a complete valid frame was committed
- seq_err  out  1  one-cycle pulse: slot out of order
- point_err  out  1  one-cycle pulse: point bit wrong for slot
- locked  out  1  high after the first committed frame, until error/stale/reset
- stale  out  1  high while the timeout counter is saturated

Behaviour:
- Reset (sync, rst=1 at edge): num1..num4=0, frame_done=seq_err=point_err=0, locked=0, stale=0, state=HUNT, shadow digits=0, expected slot=0, timeout counter=0.
- Only beats with scan_valid=1 are processed; other cycles only advance the timeout counter.
- slot = (pos - POS_SKEW) mod 4, 2-bit wrap arithmetic. pt_ok = (point == (slot==POINT_SLOT)).
- HUNT: a beat with slot==0 and pt_ok stores num in shadow[0], sets expected=1, moves to COLLECT. Any other beat is ignored silently; no error pulses in HUNT.
- COLLECT: each beat is checked in this priority:
  - slot != expected: seq_err pulse, shadow discarded, go to HUNT, locked=0.
  - else !pt_ok: point_err pulse, go to HUNT, locked=0.
  - else: store shadow[slot] and set expected = slot+1 (mod 4).
  - A good beat with slot==3 also commits shadow to the outputs (slot0→num3, slot1→num2, slot2→num1, slot3→num4). It pulses frame_done, sets locked=1, stays in COLLECT with expected=0, so back-to-back frames need no re-hunt.
- Latency: num1..num4 and frame_done update on the edge that samples the slot-3 beat and are visible the following cycle. The error pulses have the same one-cycle timing.
- Errors on the slot-3 beat: no commit. Previous committed digits are held.
- Outputs hold the last committed frame indefinitely. They are never cleared except by rst.
- Timeout counter:
  - Cleared on every scan_valid cycle; otherwise increments, saturating at TIMEOUT_CYCLES-1.
  - When it reaches saturation: stale=1, locked=0, state=HUNT.
  - stale clears on the next scan_valid cycle. That beat is processed as a HUNT beat.
  - A scan_valid on the cycle the counter would saturate wins: no stale.
- rst asserted mid-frame: partial shadow discarded, everything returns to reset values on that edge.
- Error pulses and frame_done are mutually exclusive in any cycle.

Optional Feature:
- Macro DISPLAY_CAPTURE_CHANGE_EN.
- Defined: extra output changed (1 bit, reset 0). It pulses together with frame_done only when the newly committed 16-bit value {num1,num2,num3,num4} differs from the previously committed value. The first commit after reset compares against 0.
- Undefined: no changed port and no comparison logic; the rest of the behaviour is identical.

Test Plan:
- Reset + clean frame, POS_SKEW=1:
  - Stimulus: beats (pos,num,point) = (1,7,1), (2,5,0), (3,3,0), (0,9,0).
  - Required: frame_done one cycle after the 4th beat; num3=7, num2=5, num1=3, num4=9; locked=1.
- Sequence error:
  - Stimulus: after lock, beats (1,4,1), (3,2,0).
  - Required: seq_err pulse on the second beat; locked=0; outputs still 3/5/7/9 from the prior frame; no frame_done.
- Point error:
  - Stimulus: beats (1,1,1), (2,2,1).
  - Required: point_err pulse; return to HUNT. A following correct 4-beat frame commits normally.
- Hunt alignment:
  - Stimulus: stream starting at (3,6,0), (0,8,0), then a clean frame.
  - Required: the first two beats are ignored with no error pulses; the commit occurs only after the clean frame.
- Timeout, TIMEOUT_CYCLES=8:
  - Stimulus: lock, then idle 7 cycles.
  - Required: stale=1, locked=0. One beat clears stale.
  - With a beat on the 7th idle cycle instead: stale stays 0.
- Reset mid-frame / change detect (macro defined):
  - Stimulus: rst after 2 beats; all outputs are 0. Then two identical frames.
  - Required: changed pulses on the first frame only; frame_done pulses on both.
